// File: rtl/data_stack_pkg.sv
// Shared types and operation encodings for the comproc operand stack.
// The data_stack top and its occupancy counter import this package.
package data_stack_pkg;

    // Operand width of the comproc datapath
    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    // Per-cycle operation, encoded as the concatenation {push, pop, load}
    typedef enum logic [2:0] {
        STK_OP_NONE          = 3'b000,
        STK_OP_LOAD          = 3'b001,
        STK_OP_POP           = 3'b010,
        STK_OP_POP_LOAD      = 3'b011,
        STK_OP_PUSH          = 3'b100,
        STK_OP_PUSH_LOAD     = 3'b101,
        STK_OP_PUSH_POP      = 3'b110,
        STK_OP_PUSH_POP_LOAD = 3'b111
    } stk_op_e;

    // Packs the decoder strobes into the operation enum
    function automatic stk_op_e stk_op_decode(input logic push,
                                              input logic pop,
                                              input logic load);
        return stk_op_e'({push, pop, load});
    endfunction

endpackage

// File: rtl/data_stack_cnt.sv
// Saturating up/down occupancy counter for the operand stack.
// Produces cnt, the empty/full decodes and single-cycle raw overflow and
// underflow events; push and pop together cancel and leave cnt unchanged.
module data_stack_cnt
    import data_stack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    output logic [CNT_W-1:0] cnt,
    output logic             empty,
    output logic             full,
    output logic             ovf_evt,
    output logic             udf_evt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             net_push;
    logic             net_pop;
    logic [CNT_W-1:0] cnt_next;

    assign net_push = push & ~pop;
    assign net_pop  = pop & ~push;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_MAX);

    // An event is a net move that would cross a boundary; cnt itself saturates
    assign ovf_evt = net_push & full;
    assign udf_evt = net_pop & empty;

    // Next count: step towards the requested direction unless already at the limit
    always_comb begin
        cnt_next = cnt;
        if (net_push && !full) begin
            cnt_next = cnt + CNT_ONE;
        end else if (net_pop && !empty) begin
            cnt_next = cnt - CNT_ONE;
        end
    end

    // Occupancy register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/data_stack.sv
// Operand (data) stack of the comproc stack CPU.
// Register-array shift stack: e[0] is top of stack, e[1] next of stack.
// Optional sticky overflow/underflow guard flags are built when the macro
// DATA_STACK_GUARD_EN is defined; otherwise the flags are tied low and
// clr_err is ignored. Data and count behaviour are the same either way.
module data_stack
    import data_stack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pop,
    input  logic             push,
    input  logic             load_stk,
    input  logic [15:0]      data_in,
    input  logic             clr_err,
    output logic [15:0]      stk0,
    output logic [15:0]      stk1,
    output logic [CNT_W-1:0] cnt,
    output logic             empty,
    output logic             full,
    output logic             err_ovf,
    output logic             err_udf
);

    stk_op_e op;
    word_t   e      [DEPTH];
    word_t   e_next [DEPTH];
    logic    ovf_evt;
    logic    udf_evt;

    assign op = stk_op_decode(push, pop, load_stk);

    // Occupancy counter and boundary event detection
    data_stack_cnt #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .cnt     (cnt),
        .empty   (empty),
        .full    (full),
        .ovf_evt (ovf_evt),
        .udf_evt (udf_evt)
    );

    // Next array contents: shifts happen regardless of occupancy, so a push
    // when full drops the bottom entry and a pop when empty pulls zeros up
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            e_next[i] = e[i];
        end
        unique case (op)
            STK_OP_NONE, STK_OP_PUSH_POP: begin
            end
            STK_OP_LOAD, STK_OP_PUSH_POP_LOAD: begin
                e_next[0] = data_in;
            end
            STK_OP_PUSH: begin
                for (int i = 1; i < DEPTH; i++) begin
                    e_next[i] = e[i-1];
                end
            end
            STK_OP_PUSH_LOAD: begin
                for (int i = 1; i < DEPTH; i++) begin
                    e_next[i] = e[i-1];
                end
                e_next[0] = data_in;
            end
            STK_OP_POP: begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    e_next[i] = e[i+1];
                end
                e_next[DEPTH-1] = '0;
            end
            STK_OP_POP_LOAD: begin
                for (int i = 1; i < DEPTH - 1; i++) begin
                    e_next[i] = e[i+1];
                end
                e_next[0]       = data_in;
                e_next[DEPTH-1] = '0;
            end
            default: begin
            end
        endcase
    end

    // Entry registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                e[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                e[i] <= e_next[i];
            end
        end
    end

    assign stk0 = e[0];
    assign stk1 = e[1];

`ifdef DATA_STACK_GUARD_EN
    // Sticky error flags; a new event on the same edge as clr_err keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (ovf_evt) begin
                err_ovf <= 1'b1;
            end else if (clr_err) begin
                err_ovf <= 1'b0;
            end
            if (udf_evt) begin
                err_udf <= 1'b1;
            end else if (clr_err) begin
                err_udf <= 1'b0;
            end
        end
    end
`else
    logic unused_guard;

    assign unused_guard = ^{clr_err, ovf_evt, udf_evt};
    assign err_ovf      = 1'b0;
    assign err_udf      = 1'b0;
`endif

endmodule
